// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings for the multi-channel PWM timebase and top level
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// rtl/pwm_multi_if.sv - configuration and output bundle between register block and PWM pins
interface pwm_multi_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                       enable;
    logic [WIDTH-1:0]           top;
    logic [CHANNELS*WIDTH-1:0]  comp;
    logic [CHANNELS-1:0]        pol;
    logic                       mode;
    logic                       load;
    logic                       load_ack;
    logic                       period_end;
    logic [CHANNELS-1:0]        out;
    logic [WIDTH-1:0]           counter;

    modport master (
        output enable, top, comp, pol, mode, load,
        input  load_ack, period_end, out, counter
    );

    modport slave (
        input  enable, top, comp, pol, mode, load,
        output load_ack, period_end, out, counter
    );
endinterface

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared up/down counter with period boundary detection
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WIDTH-1:0]  top,
    input  mode_e             mode,
    output logic [WIDTH-1:0]  counter,
    output logic              boundary
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else if (enable) begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (mode == MODE_EDGE) begin
            cnt_d = (cnt_q >= top) ? '0 : cnt_q + ONE;
        end else if (top == '0) begin
            cnt_d = '0;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q < top) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q - ONE;
                dir_d = DIR_DOWN;
            end
        end else begin
            cnt_d = (cnt_q > ONE) ? cnt_q - ONE : '0;
        end
        // Every arrival at zero starts a new period counting up.
        if (cnt_d == '0) begin
            dir_d = DIR_UP;
        end
    end

    always_comb begin
        counter  = cnt_q;
        boundary = enable && (cnt_d == '0);
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM top; PWM_MULTI_SHADOW_EN enables boundary-committed shadow settings
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic         clk,
    input  logic         rst,
    pwm_multi_if.slave   bus
);
    logic [WIDTH-1:0]           top_a;
    logic [CHANNELS*WIDTH-1:0]  comp_a;
    logic [CHANNELS-1:0]        pol_a;
    mode_e                      mode_a;
    logic [WIDTH-1:0]           cnt;
    logic                       boundary;
    logic [CHANNELS-1:0]        out_w;

`ifdef PWM_MULTI_SHADOW_EN
    logic [WIDTH-1:0]           top_s;
    logic [CHANNELS*WIDTH-1:0]  comp_s;
    logic [CHANNELS-1:0]        pol_s;
    mode_e                      mode_s;
    logic                       pending;
    logic                       ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_a   <= '0;
            comp_a  <= '0;
            pol_a   <= '1;
            mode_a  <= MODE_EDGE;
            top_s   <= '0;
            comp_s  <= '0;
            pol_s   <= '1;
            mode_s  <= MODE_EDGE;
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= boundary && pending;
            if (boundary && pending) begin
                top_a  <= top_s;
                comp_a <= comp_s;
                pol_a  <= pol_s;
                mode_a <= mode_s;
            end
            // A load on the committing edge refills the shadow and stays pending.
            if (bus.load) begin
                top_s  <= bus.top;
                comp_s <= bus.comp;
                pol_s  <= bus.pol;
                mode_s <= mode_e'(bus.mode);
            end
            if (bus.load) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.load_ack = ack;
`else
    assign top_a        = bus.top;
    assign comp_a       = bus.comp;
    assign pol_a        = bus.pol;
    assign mode_a       = mode_e'(bus.mode);
    assign bus.load_ack = bus.load & 1'b0;
`endif

    pwm_timebase #(
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .enable   (bus.enable),
        .top      (top_a),
        .mode     (mode_a),
        .counter  (cnt),
        .boundary (boundary)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic below;
        assign below    = cnt < comp_a[i*WIDTH +: WIDTH];
        assign out_w[i] = pol_a[i] ? below : !below;
    end

    assign bus.out        = out_w;
    assign bus.counter    = cnt;
    assign bus.period_end = boundary;

endmodule
